// File: rtl/blaster_port_arbiter.sv
// Two-host arbiter for a shared JTAG bit-bang/shift engine.
// Owner switches only at command boundaries with no replies outstanding.
module blaster_port_arbiter #(
    parameter int HOLD_CMDS = 16
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       R0_RX_EMPTY,
    input  logic       R1_RX_EMPTY,
    input  logic [7:0] R0_D_IN,
    input  logic [7:0] R1_D_IN,
    output logic       R0_RX_RD_REQ,
    output logic       R1_RX_RD_REQ,
    input  logic       R0_TX_FULL,
    input  logic       R1_TX_FULL,
    output logic       R0_TX_WR_REQ,
    output logic       R1_TX_WR_REQ,
    output logic [7:0] TX_D_OUT,
    output logic       J_RX_EMPTY,
    output logic [7:0] J_D_IN,
    input  logic       J_RX_RD_REQ,
    output logic       J_TX_FULL,
    input  logic       J_TX_WR_REQ,
    input  logic [7:0] J_D_OUT,
    output logic [1:0] GRANT,
    output logic       ERR
);

    localparam logic [7:0] HOLD_C = 8'(HOLD_CMDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic        last_q;
    logic [6:0]  pend_q;
    logic [6:0]  pend_d;
    logic [5:0]  rem_q;
    logic        rd_flag_q;
    logic [7:0]  cmd_cnt_q;
    logic        rd_d_q;
    logic        err_q;

    logic        own0;
    logic        own1;
    logic        owned;
    logic        own_empty;
    logic        oth_nempty;
    logic        wr_ok;
    logic        wr_err;
    logic        pend_inc;
    logic        release_ok;

    assign own0  = grant_q[0];
    assign own1  = grant_q[1];
    assign owned = own0 | own1;

    assign own_empty  = own0 ? R0_RX_EMPTY : R1_RX_EMPTY;
    assign oth_nempty = own0 ? ~R1_RX_EMPTY : ~R0_RX_EMPTY;

    assign J_RX_EMPTY = own0 ? R0_RX_EMPTY :
                        own1 ? R1_RX_EMPTY : 1'b1;
    assign J_D_IN     = own0 ? R0_D_IN :
                        own1 ? R1_D_IN : 8'h00;
    assign J_TX_FULL  = own0 ? R0_TX_FULL :
                        own1 ? R1_TX_FULL : 1'b1;

    assign R0_RX_RD_REQ = own0 & J_RX_RD_REQ;
    assign R1_RX_RD_REQ = own1 & J_RX_RD_REQ;

    // A reply write is legal only against an outstanding read request.
    assign wr_ok  = J_TX_WR_REQ & owned & (pend_q != 7'd0);
    assign wr_err = J_TX_WR_REQ & ~wr_ok;

    assign R0_TX_WR_REQ = own0 & wr_ok;
    assign R1_TX_WR_REQ = own1 & wr_ok;
    assign TX_D_OUT     = J_D_OUT;

    assign GRANT = grant_q;
    assign ERR   = err_q;

    assign pend_inc = rd_d_q & (
        ((state_q == CMD) & ~J_D_IN[7] & J_D_IN[6]) |
        ((state_q == DATA) & rd_flag_q));

    assign release_ok = (pend_q == 7'd0) & ~rd_d_q & ~J_RX_RD_REQ &
        (own_empty | (oth_nempty & (cmd_cnt_q == HOLD_C)));

    // Outstanding-reply counter: increment and decrement together cancel.
    always_comb begin
        pend_d = pend_q;
        if (pend_inc && !wr_ok && pend_q != 7'h7f) begin
            pend_d = pend_q + 7'd1;
        end else if (wr_ok && !pend_inc) begin
            pend_d = pend_q - 7'd1;
        end
    end

    // Read-in-flight flag, reply counter and sticky error.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_d_q <= 1'b0;
            pend_q <= 7'd0;
            err_q  <= 1'b0;
        end else begin
            rd_d_q <= J_RX_RD_REQ & owned;
            pend_q <= pend_d;
            if (wr_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Ownership and command-parse state machine.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            last_q    <= 1'b1;
            rem_q     <= 6'd0;
            rd_flag_q <= 1'b0;
            cmd_cnt_q <= 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!R0_RX_EMPTY && (R1_RX_EMPTY || last_q)) begin
                        grant_q   <= 2'b01;
                        last_q    <= 1'b0;
                        state_q   <= CMD;
                        cmd_cnt_q <= 8'd0;
                        rem_q     <= 6'd0;
                    end else if (!R1_RX_EMPTY) begin
                        grant_q   <= 2'b10;
                        last_q    <= 1'b1;
                        state_q   <= CMD;
                        cmd_cnt_q <= 8'd0;
                        rem_q     <= 6'd0;
                    end
                end
                CMD: begin
                    if (rd_d_q) begin
                        if (cmd_cnt_q != HOLD_C) begin
                            cmd_cnt_q <= cmd_cnt_q + 8'd1;
                        end
                        if (J_D_IN[7]) begin
                            rem_q     <= J_D_IN[5:0];
                            rd_flag_q <= J_D_IN[6];
                            if (J_D_IN[5:0] != 6'd0) begin
                                state_q <= DATA;
                            end
                        end
                    end else if (release_ok) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
                DATA: begin
                    if (rd_d_q) begin
                        rem_q <= rem_q - 6'd1;
                        if (rem_q == 6'd1) begin
                            state_q <= CMD;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blaster_port_arbiter.sv
// Directed bench for blaster_port_arbiter with host FIFO models.
// Engine side is driven step by step from a single initial block.
module tb_blaster_port_arbiter;

    logic       CLK;
    logic       nRST;
    logic       R0_RX_EMPTY;
    logic       R1_RX_EMPTY;
    logic [7:0] R0_D_IN;
    logic [7:0] R1_D_IN;
    logic       R0_RX_RD_REQ;
    logic       R1_RX_RD_REQ;
    logic       R0_TX_FULL;
    logic       R1_TX_FULL;
    logic       R0_TX_WR_REQ;
    logic       R1_TX_WR_REQ;
    logic [7:0] TX_D_OUT;
    logic       J_RX_EMPTY;
    logic [7:0] J_D_IN;
    logic       J_RX_RD_REQ;
    logic       J_TX_FULL;
    logic       J_TX_WR_REQ;
    logic [7:0] J_D_OUT;
    logic [1:0] GRANT;
    logic       ERR;

    int checks = 0;
    int failures = 0;

    logic [7:0] m0 [64];
    logic [7:0] m1 [64];
    int wp0 = 0;
    int rp0 = 0;
    int wp1 = 0;
    int rp1 = 0;
    int rd0 = 0;
    int rd1 = 0;
    int wr0 = 0;
    int wr1 = 0;

    blaster_port_arbiter #(.HOLD_CMDS(2)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .R0_RX_EMPTY(R0_RX_EMPTY),
        .R1_RX_EMPTY(R1_RX_EMPTY),
        .R0_D_IN(R0_D_IN),
        .R1_D_IN(R1_D_IN),
        .R0_RX_RD_REQ(R0_RX_RD_REQ),
        .R1_RX_RD_REQ(R1_RX_RD_REQ),
        .R0_TX_FULL(R0_TX_FULL),
        .R1_TX_FULL(R1_TX_FULL),
        .R0_TX_WR_REQ(R0_TX_WR_REQ),
        .R1_TX_WR_REQ(R1_TX_WR_REQ),
        .TX_D_OUT(TX_D_OUT),
        .J_RX_EMPTY(J_RX_EMPTY),
        .J_D_IN(J_D_IN),
        .J_RX_RD_REQ(J_RX_RD_REQ),
        .J_TX_FULL(J_TX_FULL),
        .J_TX_WR_REQ(J_TX_WR_REQ),
        .J_D_OUT(J_D_OUT),
        .GRANT(GRANT),
        .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign R0_RX_EMPTY = (wp0 == rp0);
    assign R1_RX_EMPTY = (wp1 == rp1);

    // Host FIFO models: data is valid the cycle after the read strobe.
    always @(posedge CLK) begin
        if (R0_RX_RD_REQ) begin
            R0_D_IN <= m0[rp0[5:0]];
            rp0 <= rp0 + 1;
            rd0 <= rd0 + 1;
        end
        if (R1_RX_RD_REQ) begin
            R1_D_IN <= m1[rp1[5:0]];
            rp1 <= rp1 + 1;
            rd1 <= rd1 + 1;
        end
        if (R0_TX_WR_REQ) wr0 <= wr0 + 1;
        if (R1_TX_WR_REQ) wr1 <= wr1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push0(input logic [7:0] b);
        m0[wp0[5:0]] = b;
        wp0++;
        #1;
    endtask

    task automatic push1(input logic [7:0] b);
        m1[wp1[5:0]] = b;
        wp1++;
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        J_RX_RD_REQ = 1'b0;
        J_TX_WR_REQ = 1'b0;
        tick();
        tick();
        wp0 = rp0;
        wp1 = rp1;
        nRST = 1'b1;
        #1;
    endtask

    task automatic eng_read(output logic [7:0] d);
        int n;
        n = 0;
        while (J_RX_EMPTY && n < 20) begin
            tick();
            n++;
        end
        chk("rx_avail", 32'(J_RX_EMPTY), 32'd0);
        J_RX_RD_REQ = 1'b1;
        tick();
        J_RX_RD_REQ = 1'b0;
        d = J_D_IN;
        tick();
    endtask

    initial begin
        logic [7:0] d;
        int b0;
        int b1;
        R0_TX_FULL = 1'b0;
        R1_TX_FULL = 1'b1;
        J_D_OUT = 8'h5A;
        J_RX_RD_REQ = 1'b0;
        J_TX_WR_REQ = 1'b0;
        nRST = 1'b1;
        R0_D_IN = 8'h00;
        R1_D_IN = 8'h00;
        #2;
        do_reset();

        chk("rst_grant", 32'(GRANT), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_jempty", 32'(J_RX_EMPTY), 32'd1);
        chk("rst_jfull", 32'(J_TX_FULL), 32'd1);
        chk("rst_jdin", 32'(J_D_IN), 32'd0);
        chk("tx_d_out", 32'(TX_D_OUT), 32'h5A);

        // single non-read command from R0
        push0(8'h2F);
        tick();
        chk("c1_grant", 32'(GRANT), 32'd1);
        chk("c1_jfull", 32'(J_TX_FULL), 32'd0);
        b0 = rd0;
        eng_read(d);
        chk("c1_data", 32'(d), 32'h2F);
        chk("c1_state", 32'(dut.state_q), 32'd1);
        chk("c1_pend", 32'(dut.pend_q), 32'd0);
        chk("c1_rdcnt", 32'(rd0 - b0), 32'd1);
        chk("c1_hold", 32'(GRANT), 32'd1);
        tick();
        chk("c1_rel", 32'(GRANT), 32'd0);

        // read command with two reply bytes
        push0(8'hC2);
        push0(8'h11);
        push0(8'h22);
        tick();
        chk("c2_grant", 32'(GRANT), 32'd1);
        b0 = wr0;
        b1 = wr1;
        eng_read(d);
        chk("c2_data", 32'(dut.state_q), 32'd2);
        eng_read(d);
        chk("c2_b1", 32'(d), 32'h11);
        chk("c2_pend1", 32'(dut.pend_q), 32'd1);
        J_TX_WR_REQ = 1'b1;
        #1;
        chk("c2_wr0", 32'(R0_TX_WR_REQ), 32'd1);
        chk("c2_wr1", 32'(R1_TX_WR_REQ), 32'd0);
        tick();
        J_TX_WR_REQ = 1'b0;
        chk("c2_pend0", 32'(dut.pend_q), 32'd0);
        eng_read(d);
        chk("c2_pend1b", 32'(dut.pend_q), 32'd1);
        chk("c2_cmd", 32'(dut.state_q), 32'd1);
        J_TX_WR_REQ = 1'b1;
        tick();
        J_TX_WR_REQ = 1'b0;
        chk("c2_wrcnt0", 32'(wr0 - b0), 32'd2);
        chk("c2_wrcnt1", 32'(wr1 - b1), 32'd0);
        chk("c2_err", 32'(ERR), 32'd0);
        tick();
        chk("c2_rel", 32'(GRANT), 32'd0);

        // R1 arrives mid-payload; grant must hold
        push0(8'h83);
        push0(8'h01);
        push0(8'h02);
        push0(8'h03);
        tick();
        chk("c3_grant", 32'(GRANT), 32'd1);
        eng_read(d);
        eng_read(d);
        push1(8'h00);
        chk("c3_hold1", 32'(GRANT), 32'd1);
        chk("c3_rem", 32'(dut.rem_q), 32'd2);
        eng_read(d);
        chk("c3_hold2", 32'(GRANT), 32'd1);
        eng_read(d);
        chk("c3_hold3", 32'(GRANT), 32'd1);
        chk("c3_state", 32'(dut.state_q), 32'd1);
        tick();
        chk("c3_rel", 32'(GRANT), 32'd0);
        tick();
        chk("c3_r1", 32'(GRANT), 32'd2);
        chk("c3_jfull", 32'(J_TX_FULL), 32'd1);
        eng_read(d);
        tick();
        chk("c3_rel1", 32'(GRANT), 32'd0);

        // both busy: alternate every HOLD_CMDS=2 commands
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push0(8'h00);
            push1(8'h00);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] e;
            e = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("alt_own", 32'(GRANT), 32'(e));
            eng_read(d);
            tick();
            chk("alt_mid", 32'(GRANT), 32'(e));
            eng_read(d);
            chk("alt_end", 32'(GRANT), 32'(e));
            tick();
            chk("alt_gap", 32'(GRANT), 32'd0);
            tick();
        end

        // stray write with no owner
        do_reset();
        chk("e_grant", 32'(GRANT), 32'd0);
        J_TX_WR_REQ = 1'b1;
        #1;
        chk("e_wr0", 32'(R0_TX_WR_REQ), 32'd0);
        chk("e_wr1", 32'(R1_TX_WR_REQ), 32'd0);
        tick();
        J_TX_WR_REQ = 1'b0;
        chk("e_set", 32'(ERR), 32'd1);
        tick();
        tick();
        chk("e_sticky", 32'(ERR), 32'd1);
        nRST = 1'b0;
        #1;
        chk("e_clr", 32'(ERR), 32'd0);
        tick();
        nRST = 1'b1;
        #1;

        // reset in the middle of a payload
        push0(8'h85);
        push0(8'h01);
        push0(8'h02);
        tick();
        eng_read(d);
        chk("r_state", 32'(dut.state_q), 32'd2);
        chk("r_rem", 32'(dut.rem_q), 32'd5);
        J_RX_RD_REQ = 1'b1;
        #1;
        chk("r_rd_on", 32'(R0_RX_RD_REQ), 32'd1);
        nRST = 1'b0;
        #1;
        chk("r_rd_off", 32'(R0_RX_RD_REQ), 32'd0);
        chk("r_grant", 32'(GRANT), 32'd0);
        chk("r_wr", 32'(R0_TX_WR_REQ), 32'd0);
        J_RX_RD_REQ = 1'b0;
        tick();
        wp0 = rp0;
        wp1 = rp1;
        nRST = 1'b1;
        push0(8'h00);
        tick();
        chk("r_regrant", 32'(GRANT), 32'd1);
        chk("r_cmd", 32'(dut.state_q), 32'd1);
        chk("r_rem0", 32'(dut.rem_q), 32'd0);
        chk("r_pend0", 32'(dut.pend_q), 32'd0);
        eng_read(d);
        tick();
        chk("r_rel", 32'(GRANT), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
